// File: rtl/cnn_defs.sv
// ---------------------------------------------------------------------------
// cnn_defs -- shared definitions for the 2-parallel conv output reader.
//
// Contents:
//   DEF_PIX_W       default pixel width in bits
//   Y0_LSB / Y1_LSB bit offsets of y0 and y1 inside a stored pair; pairs are
//                   packed {y1, y0}, so the even (earlier) pixel sits in the
//                   low half
//   clog2()         ceiling log2 usable in parameter and port declarations
// ---------------------------------------------------------------------------
package cnn_defs;

  localparam int DEF_PIX_W = 8;

  // Packing order of a pixel pair: {y1, y0}. Offsets are in units of PIX_W.
  localparam int Y0_LSB = 0;
  localparam int Y1_LSB = 1;

  // Ceiling log2; clog2(1) = 0, clog2(2) = 1, clog2(4) = 2, clog2(5) = 3.
  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/cnn_pair_fifo.sv
// ---------------------------------------------------------------------------
// cnn_pair_fifo -- generic DEPTH x WIDTH synchronous-write FIFO.
//
// The head entry is presented combinationally on rdata so the consumer can
// mux it without an extra cycle of latency.
//
// Ports:
//   clk    in   clock, all state on posedge
//   rst    in   asynchronous active-high reset (pointers and level to 0)
//   push   in   write wdata this cycle (ignored while full)
//   pop    in   retire the head entry this cycle (ignored while empty)
//   wdata  in   WIDTH  entry to write
//   rdata  out  WIDTH  head entry (undefined while empty)
//   level  out  clog2(DEPTH)+1  entries currently stored
//   full   out  level == DEPTH
//   empty  out  level == 0
// ---------------------------------------------------------------------------
module cnn_pair_fifo
  import cnn_defs::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic [WIDTH-1:0]      wdata,
  output logic [WIDTH-1:0]      rdata,
  output logic [clog2(DEPTH):0] level,
  output logic                  full,
  output logic                  empty
);

  localparam int AW = clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q,  level_d;

  logic do_push;
  logic do_pop;

  assign full  = (level_q == LW'(DEPTH));
  assign empty = (level_q == '0);
  assign level = level_q;
  assign rdata = mem_q[rd_ptr_q];

  // No bypass: a full FIFO refuses a push even if the head leaves this cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    // DEPTH is a power of two, so pointer overflow is the wrap.
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    level_d  = level_q;
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage carries no reset so it can map onto plain memory.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

endmodule

// File: rtl/cnn_p2s_reader.sv
// ---------------------------------------------------------------------------
// cnn_p2s_reader -- buffers pixel pairs from the 2-parallel conv core and
// re-emits them one pixel per clock under valid/ready, marking frame end.
//
// Ports:
//   clk        in   clock, all state on posedge
//   rst        in   asynchronous active-high reset
//   in_valid   in   pair present on in_y0/in_y1
//   in_ready   out  FIFO can accept a pair this cycle
//   in_y0      in   PIX_W  even (first) pixel of pair
//   in_y1      in   PIX_W  odd (second) pixel of pair
//   out_valid  out  out_data holds a valid pixel
//   out_ready  in   downstream accepts out_data this cycle
//   out_data   out  PIX_W  serialized pixel (0 when out_valid=0)
//   out_last   out  out_data is the last pixel of a frame
//   level      out  clog2(DEPTH)+1  pairs currently stored
//   err_ovf    out  sticky: in_valid seen while FIFO full
// ---------------------------------------------------------------------------
module cnn_p2s_reader
  import cnn_defs::*;
#(
  parameter int PIX_W     = DEF_PIX_W,
  parameter int DEPTH     = 4,
  parameter int FRAME_LEN = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [PIX_W-1:0]      in_y0,
  input  logic [PIX_W-1:0]      in_y1,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [PIX_W-1:0]      out_data,
  output logic                  out_last,
  output logic [clog2(DEPTH):0] level,
  output logic                  err_ovf
);

  localparam int CNT_W = clog2(FRAME_LEN);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);

  logic [2*PIX_W-1:0] head;
  logic [2*PIX_W-1:0] pair_in;
  logic               full;
  logic               empty;
  logic               push;
  logic               pop;
  logic               fire;

  logic             sel_q,     sel_d;
  logic [CNT_W-1:0] pix_cnt_q, pix_cnt_d;
  logic             err_ovf_q, err_ovf_d;

  assign pair_in = {in_y1, in_y0};

  assign in_ready  = !full;
  assign out_valid = !empty;
  assign push      = in_valid && !full;
  assign fire      = out_valid && out_ready;
  // The pair leaves the FIFO only once its second pixel (y1) is taken.
  assign pop       = fire && sel_q;

  cnn_pair_fifo #(
    .WIDTH (2 * PIX_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (pair_in),
    .rdata (head),
    .level (level),
    .full  (full),
    .empty (empty)
  );

  always_comb begin
    out_data = '0;
    if (out_valid) begin
      out_data = sel_q ? head[Y1_LSB*PIX_W +: PIX_W]
                       : head[Y0_LSB*PIX_W +: PIX_W];
    end
  end

  // FRAME_LEN is even and frames start on y0, so this only fires on y1.
  assign out_last = out_valid && (pix_cnt_q == LAST_CNT);
  assign err_ovf  = err_ovf_q;

  always_comb begin
    sel_d     = sel_q;
    pix_cnt_d = pix_cnt_q;
    err_ovf_d = err_ovf_q | (in_valid & full);
    if (fire) begin
      sel_d     = ~sel_q;
      pix_cnt_d = (pix_cnt_q == LAST_CNT) ? '0 : pix_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_q     <= 1'b0;
      pix_cnt_q <= '0;
      err_ovf_q <= 1'b0;
    end else begin
      sel_q     <= sel_d;
      pix_cnt_q <= pix_cnt_d;
      err_ovf_q <= err_ovf_d;
    end
  end

endmodule

// File: tb/tb_cnn_p2s_reader.sv
// ---------------------------------------------------------------------------
// tb_cnn_p2s_reader -- scoreboard bench for cnn_p2s_reader.
// Every accepted pair pushes its two expected pixels (with expected out_last
// from a bench-side frame counter) onto a queue; the monitor pops and
// compares on each output handshake.
// ---------------------------------------------------------------------------
module tb_cnn_p2s_reader;

  localparam int PIX_W     = 8;
  localparam int DEPTH     = 4;
  localparam int FRAME_LEN = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [PIX_W-1:0] in_y0;
  logic [PIX_W-1:0] in_y1;
  logic             out_valid;
  logic             out_ready;
  logic [PIX_W-1:0] out_data;
  logic             out_last;
  logic [2:0]       level;
  logic             err_ovf;

  int n_tests = 0;
  int n_fail  = 0;
  int n_out   = 0;
  int exp_cnt = 0;
  logic [PIX_W:0] exp_q [$];   // {last, data}

  always #5 clk = ~clk;

  cnn_p2s_reader #(
    .PIX_W     (PIX_W),
    .DEPTH     (DEPTH),
    .FRAME_LEN (FRAME_LEN)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_y0     (in_y0),
    .in_y1     (in_y1),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .level     (level),
    .err_ovf   (err_ovf)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_pix(input logic [PIX_W-1:0] d);
    exp_q.push_back({(exp_cnt == FRAME_LEN - 1), d});
    exp_cnt = (exp_cnt + 1) % FRAME_LEN;
  endtask

  // Drive one pair for one cycle; the model records it only if accepted.
  task automatic push_pair(input logic [PIX_W-1:0] y0, input logic [PIX_W-1:0] y1);
    in_valid = 1'b1;
    in_y0    = y0;
    in_y1    = y1;
    if (in_ready) begin
      expect_pix(y0);
      expect_pix(y1);
    end
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_ready();
    int t = 0;
    while (!in_ready && t < 100) begin
      step();
      t++;
    end
    if (t >= 100) check_eq("in_ready_timeout", in_ready, 1);
  endtask

  task automatic drain(input int max_cycles);
    int t = 0;
    out_ready = 1'b1;
    while (out_valid && t < max_cycles) begin
      step();
      t++;
    end
    check_eq("drain_done", out_valid, 0);
    check_eq("drain_queue_empty", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    exp_q.delete();
    exp_cnt  = 0;
    step();
    step();
    rst = 1'b0;
  endtask

  // Output monitor: inputs change just after posedge, so the handshake seen
  // here at negedge is the one that completes on the next posedge.
  always @(negedge clk) begin
    logic [PIX_W:0] e;
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check_eq("out_unexpected_pixel", exp_q.size(), 1);
      end else begin
        e = exp_q.pop_front();
        check_eq("out_data", {24'd0, out_data}, {24'd0, e[PIX_W-1:0]});
        check_eq("out_last", out_last, e[PIX_W]);
        $display("[TB] out pixel 0x%02h last=%0b", out_data, out_last);
      end
      n_out++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int snap;

    // Reset with in_valid held high: nothing may be captured.
    rst       = 1'b1;
    in_valid  = 1'b1;
    in_y0     = 8'hAA;
    in_y1     = 8'hBB;
    out_ready = 1'b0;
    step();
    step();
    check_eq("rst_in_ready", in_ready, 1);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_out_data", out_data, 0);
    check_eq("rst_out_last", out_last, 0);
    check_eq("rst_level", level, 0);
    check_eq("rst_err_ovf", err_ovf, 0);
    in_valid = 1'b0;
    rst      = 1'b0;
    step();
    check_eq("post_rst_out_valid", out_valid, 0);

    // Single pair, one-cycle latency, y0 then y1 on consecutive cycles.
    out_ready = 1'b1;
    push_pair(8'h11, 8'h22);
    check_eq("single_valid", out_valid, 1);
    check_eq("single_y0", out_data, 8'h11);
    check_eq("single_level", level, 1);
    step();
    check_eq("single_y1", out_data, 8'h22);
    step();
    check_eq("single_done_valid", out_valid, 0);
    check_eq("single_done_level", level, 0);

    // Backpressure: fill to DEPTH, fifth pair is dropped and flagged.
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (k == 4) begin
        check_eq("full_in_ready", in_ready, 0);
        check_eq("full_level", level, DEPTH);
        check_eq("pre_ovf_err", err_ovf, 0);
      end
      push_pair(8'(8'h30 + 2 * k), 8'(8'h31 + 2 * k));
    end
    check_eq("ovf_err", err_ovf, 1);
    check_eq("ovf_level", level, DEPTH);
    step();
    check_eq("stall_data", out_data, 8'h30);
    snap = n_out;
    drain(40);
    check_eq("drain_count", n_out - snap, 8);
    check_eq("drain_level", level, 0);

    // Frame marking: 10 pairs 0..19 from a fresh frame.
    do_reset();
    check_eq("reset_clears_ovf", err_ovf, 0);
    out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      wait_ready();
      push_pair(8'(2 * k), 8'(2 * k + 1));
      step();
    end
    drain(40);

    // Simultaneous push and pair-pop at level 2.
    out_ready = 1'b0;
    push_pair(8'hA0, 8'hA1);
    push_pair(8'hB0, 8'hB1);
    check_eq("simul_pre_level", level, 2);
    out_ready = 1'b1;
    step();
    check_eq("simul_y1_shown", out_data, 8'hA1);
    push_pair(8'hC0, 8'hC1);
    check_eq("simul_level", level, 2);
    drain(40);

    // Reset between y0 and y1 of a pair.
    do_reset();
    out_ready = 1'b1;
    push_pair(8'h11, 8'h22);
    step();
    check_eq("midrst_y1_pending", out_data, 8'h22);
    rst = 1'b1;
    exp_q.delete();
    exp_cnt = 0;
    #1;
    check_eq("midrst_async_valid", out_valid, 0);
    step();
    rst = 1'b0;
    step();
    check_eq("midrst_idle_valid", out_valid, 0);
    push_pair(8'h55, 8'h66);
    check_eq("midrst_first_y0", out_data, 8'h55);
    check_eq("midrst_first_last", out_last, 0);
    for (int k = 1; k < 8; k++) begin
      wait_ready();
      push_pair(8'(8'h60 + 2 * k), 8'(8'h61 + 2 * k));
    end
    drain(60);

    check_eq("final_queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
